// File: rtl/mm_pkg.sv
// mm_pkg: shared definitions for the memory-mapped coprocessor wrapper.
// Holds the sequencer state encoding and the output buffer depth.
package mm_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    FLUSH = ST_FLUSH,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/mm_fifo2.sv
// mm_fifo2: 2-entry synchronous FIFO used as the stream output buffer.
// Head is presented combinationally; pushes into a full FIFO are only
// accepted when a pop happens in the same cycle.
module mm_fifo2
  import mm_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [FIFO_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count < 2'(FIFO_DEPTH)) || pop_ok);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; storage cleared so the head reads zero out of reset
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mm_front_end.sv
// mm_front_end: read-side sequencer. On start it reads size consecutive
// words from a 1-cycle-latency local memory and streams them out through
// a 2-entry buffer with consumer backpressure, tagging the final word.
// Optional feature macro: MM_FE_STALL_CNT_EN adds the stall_cnt port and
// a saturating count of backpressured cycles while busy.
module mm_front_end
  import mm_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] size,
  output logic              rden,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              dout_last,
  input  logic              dout_full,
  output logic              busy,
  output logic              done
`ifdef MM_FE_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  state_t            state;
  logic [ADDR_W-1:0] size_q;
  logic              last_rd;
  logic              pop;
  logic [2:0]        credit_sum;
  logic [1:0]        fifo_cnt;
  logic [DATA_W:0]   head;

  // Stage p1: a read was issued last cycle, its data is on rdata now
  logic              vld_p1;
  logic              last_p1;

  assign dout       = head[DATA_W-1:0];
  assign dout_last  = head[DATA_W];
  assign dout_valid = (fifo_cnt != 2'd0);
  assign pop        = dout_valid && !dout_full;
  assign busy       = (state == READ) || (state == FLUSH);
  assign done       = (state == DONE);

  // Words already buffered plus the one in flight must leave room for the next read.
  // A pop in the same cycle frees a slot, which keeps full throughput at one word/cycle.
  assign credit_sum = 3'(fifo_cnt) + 3'(vld_p1);
  assign last_rd    = (addr == (size_q - ADDR_W'(1)));
  assign rden       = (state == READ) &&
                      ((credit_sum <= 3'd1) || ((credit_sum == 3'd2) && pop));

  // Sequencer state, latched job size, address counter and read-return tracking
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      size_q  <= '0;
      addr    <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= rden;
      last_p1 <= rden && last_rd;
      case (state)
        IDLE: begin
          if (start) begin
            if (size != '0) begin
              state  <= READ;
              size_q <= size;
              addr   <= '0;
            end else begin
              state <= DONE;
            end
          end
        end
        READ: begin
          if (rden) begin
            addr <= addr + ADDR_W'(1);
            if (last_rd) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (pop && dout_last) state <= DONE;
        end
        DONE: begin
          if (!start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1 -> buffer: returning word enters the FIFO with its last tag
  mm_fifo2 #(
    .W(DATA_W + 1)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (vld_p1),
    .pop     (pop),
    .wdata   ({last_p1, rdata}),
    .head    (head),
    .count   (fifo_cnt)
  );

`ifdef MM_FE_STALL_CNT_EN
  // Backpressure cycles while a job is active; restarts at each accepted launch
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      stall_cnt <= '0;
    end else if (busy && dout_valid && dout_full && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
